// File: rtl/mc_controller.sv
// Multicycle MIPS-style main controller.
// Moore FSM sequencing fetch/decode/execute/writeback; per-state controls are
// registered alongside the state, and the write strobes are gated by reset_n
// so they drop the instant reset is asserted.
module mc_controller (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       iord,
    output logic       irwrite,
    output logic       memwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       pcen,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    // ALU_NONE only appears for the unused state codes, which drive all zeros
    typedef enum logic [1:0] {
        ALU_ADD   = 2'd0,
        ALU_SUB   = 2'd1,
        ALU_FUNCT = 2'd2,
        ALU_NONE  = 2'd3
    } aluop_t;

    typedef struct packed {
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       iord;
        logic       irwrite;
        logic       memwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       pcwrite;
        logic       branch;
        aluop_t     aluop;
    } ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t r_state;
    state_t w_nextState;
    ctrl_t  r_ctrl;

    // Control word presented while the FSM sits in a given state
    function automatic ctrl_t ctrlFor(input state_t s);
        ctrl_t c;
        c       = '0;
        c.aluop = ALU_ADD;
        case (s)
            FETCH:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            DECODE:  c.alusrcb = 2'b11;
            MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            MEMRD:   c.iord = 1'b1;
            MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALU_FUNCT; end
            RTYPEWB: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            BEQEX:   begin c.alusrca = 1'b1; c.aluop = ALU_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
            ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            ADDIWB:  c.regwrite = 1'b1;
            JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default: c.aluop = ALU_NONE;
        endcase
        return c;
    endfunction

    // Next-state selection; unknown opcodes fall back to FETCH as a nop
    always_comb begin
        w_nextState = FETCH;
        case (r_state)
            FETCH:   w_nextState = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_nextState = MEMADR;
                    OP_RTYPE:     w_nextState = RTYPEEX;
                    OP_BEQ:       w_nextState = BEQEX;
                    OP_ADDI:      w_nextState = ADDIEX;
                    OP_J:         w_nextState = JEX;
                    default:      w_nextState = FETCH;
                endcase
            end
            MEMADR:  w_nextState = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   w_nextState = MEMWB;
            RTYPEEX: w_nextState = RTYPEWB;
            ADDIEX:  w_nextState = ADDIWB;
            default: w_nextState = FETCH;
        endcase
    end

    // State register plus the control word for the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= FETCH;
            r_ctrl  <= ctrlFor(FETCH);
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= ctrlFor(w_nextState);
        end
    end

    // ALU select; funct only matters while the R-type execute word is active
    always_comb begin
        alucontrol = 3'b000;
        case (r_ctrl.aluop)
            ALU_ADD: alucontrol = 3'b010;
            ALU_SUB: alucontrol = 3'b110;
            ALU_FUNCT: begin
                case (funct)
                    6'b100000: alucontrol = 3'b010;
                    6'b100010: alucontrol = 3'b110;
                    6'b100100: alucontrol = 3'b000;
                    6'b100101: alucontrol = 3'b001;
                    6'b101010: alucontrol = 3'b111;
                    default:   alucontrol = 3'b010;
                endcase
            end
            default: alucontrol = 3'b000;
        endcase
    end

    assign state    = r_state;
    assign alusrca  = r_ctrl.alusrca;
    assign alusrcb  = r_ctrl.alusrcb;
    assign pcsrc    = r_ctrl.pcsrc;
    assign iord     = r_ctrl.iord;
    assign regdst   = r_ctrl.regdst;
    assign memtoreg = r_ctrl.memtoreg;
    assign irwrite  = r_ctrl.irwrite  & reset_n;
    assign memwrite = r_ctrl.memwrite & reset_n;
    assign regwrite = r_ctrl.regwrite & reset_n;
    assign pcen     = reset_n & (r_ctrl.pcwrite | (r_ctrl.branch & zero));

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: the stimulus process walks each
// instruction through the state path its opcode implies and queues the
// expected control vector for every cycle; a monitor pops and compares.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic [2:0] alucontrol;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcen;
    logic [3:0] state;

    typedef struct {
        logic [18:0] vec;
        string       tag;
    } exp_t;

    exp_t expQ[$];
    int   path[$];
    int   checks = 0;
    int   errors = 0;

    mc_controller dut (
        .clk(clk), .reset_n(reset_n), .op(op), .funct(funct), .zero(zero),
        .alucontrol(alucontrol), .alusrca(alusrca), .alusrcb(alusrcb),
        .pcsrc(pcsrc), .iord(iord), .irwrite(irwrite), .memwrite(memwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .pcen(pcen), .state(state)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Observed outputs packed in the same field order as the model
    function automatic logic [18:0] actualVec();
        return {state, alucontrol, alusrca, alusrcb, pcsrc,
                iord, irwrite, memwrite, regdst, memtoreg, regwrite, pcen};
    endfunction

    // Reference: the controls the datapath should see in a given state
    function automatic logic [18:0] modelVec(input int st, input logic [5:0] f,
                                             input logic z, input bit inReset);
        logic [2:0] alu;
        logic       a, ir, pw, mw, dst, m2r, rw, io, br;
        logic [1:0] b, ps;
        alu = 3'b010; a = 0; b = 2'b00; ps = 2'b00;
        io = 0; ir = 0; mw = 0; dst = 0; m2r = 0; rw = 0; pw = 0; br = 0;
        if (st == 0)  begin b = 2'b01; ir = 1; pw = 1; end
        if (st == 1)  b = 2'b11;
        if (st == 2 || st == 9) begin a = 1; b = 2'b10; end
        if (st == 3)  io = 1;
        if (st == 4)  begin m2r = 1; rw = 1; end
        if (st == 5)  begin io = 1; mw = 1; end
        if (st == 6) begin
            a = 1;
            if      (f == 6'b100010) alu = 3'b110;
            else if (f == 6'b100100) alu = 3'b000;
            else if (f == 6'b100101) alu = 3'b001;
            else if (f == 6'b101010) alu = 3'b111;
        end
        if (st == 7)  begin dst = 1; rw = 1; end
        if (st == 8)  begin a = 1; alu = 3'b110; ps = 2'b01; br = 1; end
        if (st == 10) rw = 1;
        if (st == 11) begin ps = 2'b10; pw = 1; end
        if (inReset) begin ir = 0; mw = 0; rw = 0; pw = 0; br = 0; end
        return {4'(st), alu, a, b, ps, io, ir, mw, dst, m2r, rw, pw | (br & z)};
    endfunction

    // State path of one instruction, FETCH included
    task automatic buildPath(input logic [5:0] o);
        case (o)
            6'b100011: path = '{0, 1, 2, 3, 4};
            6'b101011: path = '{0, 1, 2, 5};
            6'b000000: path = '{0, 1, 6, 7};
            6'b001000: path = '{0, 1, 9, 10};
            6'b000100: path = '{0, 1, 8};
            6'b000010: path = '{0, 1, 11};
            default:   path = '{0, 1};
        endcase
    endtask

    task automatic checkOutput(input string name, input logic [18:0] act,
                               input logic [18:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %05h expected %05h (state %0d vs %0d)",
                     name, act, exp, act[18:15], exp[18:15]);
        end
    endtask

    function automatic logic [5:0] randFunct();
        logic [5:0] legal[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        if ($urandom_range(0, 3) != 0) return legal[$urandom_range(0, 4)];
        return 6'($urandom);
    endfunction

    // Run one instruction from FETCH; entered and left at posedge+1
    task automatic applyStimulus(input logic [5:0] o, input int forceZero);
        exp_t e;
        op = o;
        buildPath(o);
        foreach (path[k]) begin
            funct = randFunct();
            zero  = (forceZero >= 0) ? logic'(forceZero) : logic'($urandom_range(0, 1));
            e.vec = modelVec(path[k], funct, zero, 1'b0);
            e.tag = $sformatf("op=%06b step%0d", o, k);
            expQ.push_back(e);
            @(posedge clk); #1;
        end
    endtask

    // Hold reset across one clock, queueing the forced-reset vector
    task automatic resetCycle();
        exp_t e;
        reset_n = 1'b0;
        e.vec = modelVec(0, funct, zero, 1'b1);
        e.tag = "reset";
        expQ.push_back(e);
        @(posedge clk); #1;
    endtask

    // Monitor: compare against the queued expectation once per cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() != 0) begin
                e = expQ.pop_front();
                checkOutput(e.tag, actualVec(), e.vec);
            end
        end
    end

    // Watchdog so a stuck run still reports
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [5:0] known[6] = '{6'b100011, 6'b101011, 6'b000000,
                                 6'b000100, 6'b001000, 6'b000010};
        logic [5:0] o;
        exp_t e;
        int wait_cycles;

        @(posedge clk); #1;
        resetCycle();
        resetCycle();
        reset_n = 1'b1;

        // Directed instruction mix, beq with both zero polarities
        applyStimulus(6'b100011, -1);
        applyStimulus(6'b000000, -1);
        applyStimulus(6'b000100, 1);
        applyStimulus(6'b000100, 0);
        applyStimulus(6'b101011, -1);
        applyStimulus(6'b111111, -1);
        applyStimulus(6'b000010, -1);
        applyStimulus(6'b001000, -1);

        // Store aborted by an asynchronous reset in the middle of MEMWR
        op = 6'b101011;
        buildPath(op);
        for (int k = 0; k < 4; k++) begin
            e.vec = modelVec(path[k], funct, zero, 1'b0);
            e.tag = $sformatf("abort step%0d", k);
            expQ.push_back(e);
            if (k < 3) begin @(posedge clk); #1; end
        end
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async reset mid-MEMWR", actualVec(), modelVec(0, funct, zero, 1'b1));
        @(posedge clk); #1;
        resetCycle();
        reset_n = 1'b1;
        applyStimulus(6'b100011, -1);

        // Randomised instruction stream including unknown opcodes
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do o = 6'($urandom);
                while (o inside {known});
            end else begin
                o = known[$urandom_range(0, 5)];
            end
            applyStimulus(o, -1);
        end

        wait_cycles = 0;
        while (expQ.size() != 0 && wait_cycles < 10) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard drain: %0d left, expected 0", expQ.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; the datapath width is fixed at 32 bits outside this block.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 op  input  6  instruction opcode field [31:26] from the instruction register.
REQ-005 funct  input  6  instruction funct field [5:0].
REQ-006 zero  input  1  ALU zero flag, combinational from the ALU in the same cycle.
REQ-007 alucontrol  output  3  ALU operation select: 000 and, 001 or, 010 add, 110 sub, 111 slt.
REQ-008 alusrca  output  1  ALU A mux: 0 = PC, 1 = register A.
REQ-009 alusrcb  output  2  ALU B mux: 00 = reg B, 01 = constant 4, 10 = sign-extended imm, 11 = imm<<2.
REQ-010 pcsrc  output  2  PC mux: 00 = ALU result, 01 = ALUOut register, 10 = jump target.
REQ-011 iord, irwrite, memwrite, regdst, memtoreg, regwrite  output  1 each  standard multicycle datapath controls.
REQ-012 pcen  output  1  PC register write enable.
REQ-013 state  output  4  current state code, for debug and verification.

Function
REQ-014 The block SHALL be a Moore FSM with these state codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11.
REQ-015 Transitions:
- FETCH->DECODE.
- DECODE on op: 100011/101011 -> MEMADR; 000000 -> RTYPEEX; 000100 -> BEQEX; 001000 -> ADDIEX; 000010 -> JEX; any other op -> FETCH (executes as a nop).
- MEMADR: op=100011 -> MEMRD, otherwise -> MEMWR.
- MEMRD->MEMWB; RTYPEEX->RTYPEWB; ADDIEX->ADDIWB.
- MEMWB, MEMWR, RTYPEWB, BEQEX, ADDIWB, JEX -> FETCH.
- Codes 12-15 -> FETCH, with all outputs 0.
REQ-016 Per-state outputs (every output not listed SHALL be 0):
- FETCH: alusrcb=01, irwrite=1, pcwrite=1, ALU op add.
- DECODE: alusrcb=11, ALU op add.
- MEMADR: alusrca=1, alusrcb=10, ALU op add.
- MEMRD: iord=1.
- MEMWB: memtoreg=1, regwrite=1.
- MEMWR: iord=1, memwrite=1.
- RTYPEEX: alusrca=1, alusrcb=00, ALU op from funct.
- RTYPEWB: regdst=1, regwrite=1.
- BEQEX: alusrca=1, alusrcb=00, ALU op sub, pcsrc=01, branch=1.
- ADDIEX: alusrca=1, alusrcb=10, ALU op add.
- ADDIWB: regwrite=1.
- JEX: pcsrc=10, pcwrite=1.
REQ-017 In RTYPEEX, alucontrol SHALL decode funct as follows: 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, any other value -> 010.
REQ-018 In all states other than RTYPEEX and BEQEX, alucontrol SHALL be 010; in BEQEX it SHALL be 110.
REQ-019 pcen SHALL equal pcwrite OR (branch AND zero), combinationally and in the same cycle.
REQ-020 funct and zero SHALL have no effect outside RTYPEEX and BEQEX respectively.
REQ-021 Instruction latency in cycles, including FETCH: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, unknown opcode 2.

Reset
REQ-022 While reset_n=0, state SHALL be FETCH, applied asynchronously.
REQ-023 While reset_n=0, irwrite, pcen, memwrite and regwrite SHALL be forced to 0; all other outputs SHALL show their FETCH values.
REQ-024 Asserting reset in any state SHALL abort the instruction immediately; no write strobe SHALL be asserted during the reset.
REQ-025 After reset_n rises, the first rising edge SHALL see FETCH with irwrite=1 and pcen=1.

Verification
REQ-026 Reset then op=100011 -> state sequence 0,1,2,3,4,0; regwrite=1 only in state 4; memtoreg=1 in state 4.
REQ-027 op=000000, funct=101010 -> state sequence 0,1,6,7,0; alucontrol=111 in state 6; regdst=1 and regwrite=1 in state 7.
REQ-028 op=000100: with zero=1 in BEQEX -> pcen=1, pcsrc=01; with zero=0 -> pcen=0; next state 0 in both cases.
REQ-029 op=101011 -> sequence 0,1,2,5,0 with memwrite=1 and iord=1 only in state 5; op=111111 -> sequence 0,1,0 with no write strobe asserted.
REQ-030 reset_n pulled low asynchronously mid-MEMWR -> memwrite drops to 0 without a clock edge and state=0; after release, FETCH runs normally.
REQ-031 op=000010 -> sequence 0,1,11,0 with pcsrc=10 and pcen=1 in state 11.
